count_pwm_gen: RTL and testbench

//  Downstream consumer of the free-running 6-bit up counter: compares the

---
 rtl/count_pwm_gen.sv | 161 ++++++++++++++++
 tb/tb_count_pwm_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_pwm_gen.sv
// count_pwm_gen: PWM generator driven by an external free-running up counter.
// The duty value is loaded through a valid/ready handshake. A loaded value
// takes effect only at a counter wrap, so no PWM period is ever cut short.
// The block also watches the count stream for illegal jumps.
module count_pwm_gen #(
  parameter int unsigned WIDTH        = 6,
  parameter int unsigned DEFAULT_DUTY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  input  logic             en,
  input  logic [WIDTH:0]   duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             wrap_pulse,
  output logic [7:0]       wrap_cnt,
  output logic             seq_err
);

  localparam int unsigned DW     = WIDTH + 1;
  localparam int unsigned CW     = 8;
  localparam int unsigned FULL_I = 1 << WIDTH;

  localparam logic [DW-1:0]    FULL_DUTY = DW'(FULL_I);
  localparam logic [DW-1:0]    RST_DUTY  = (DEFAULT_DUTY > FULL_I) ? FULL_DUTY : DW'(DEFAULT_DUTY);
  localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};

  // Classification of the incoming count relative to the previous one.
  typedef enum logic [2:0] {
    C_NONE   = 3'd0,
    C_WRAP   = 3'd1,
    C_STEP   = 3'd2,
    C_RESYNC = 3'd3,
    C_ERROR  = 3'd4
  } cls_t;

  // The pending-duty slot is either empty or holds a value waiting for a wrap.
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_PEND  = 1'b1
  } pend_state_t;

  logic [WIDTH-1:0] prev_cnt;
  logic             prev_valid;
  cls_t             cls_c;
  logic             wrap_c;
  logic             err_c;

  pend_state_t      state;
  pend_state_t      state_nxt;
  logic [DW-1:0]    pending_duty;
  logic [DW-1:0]    pending_nxt;
  logic [DW-1:0]    active_duty;
  logic [DW-1:0]    active_nxt;
  logic [DW-1:0]    eff_duty_c;
  logic [DW-1:0]    sat_duty_c;
  logic             accept_c;

  // History of the count stream, used for sequence classification.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_cnt   <= '0;
      prev_valid <= 1'b0;
    end else begin
      prev_cnt   <= count_in;
      prev_valid <= 1'b1;
    end
  end

  // Classify this cycle's count. Nothing is classified until history exists.
  always_comb begin
    cls_c = C_NONE;
    if (prev_valid) begin
      if (prev_cnt == CNT_MAX && count_in == '0) begin
        cls_c = C_WRAP;
      end else if (count_in == prev_cnt ||
                   (prev_cnt != CNT_MAX && count_in == prev_cnt + WIDTH'(1))) begin
        cls_c = C_STEP;
      end else if (count_in == '0) begin
        cls_c = C_RESYNC;
      end else begin
        cls_c = C_ERROR;
      end
    end
  end

  assign wrap_c = (cls_c == C_WRAP);
  assign err_c  = (cls_c == C_ERROR);

  // Clamp requested duty to a full period.
  assign sat_duty_c = (duty_in > FULL_DUTY) ? FULL_DUTY : duty_in;
  assign accept_c   = duty_valid && duty_ready;

  // Pending-slot state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Pending-slot next state, duty selection and the compare duty for this cycle.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending_duty;
    active_nxt  = active_duty;
    eff_duty_c  = active_duty;
    case (state)
      S_EMPTY: begin
        // A new duty accepted on a wrap cycle waits for the next wrap.
        if (accept_c) begin
          pending_nxt = sat_duty_c;
          state_nxt   = S_PEND;
        end
      end
      S_PEND: begin
        // Apply at the boundary. The wrap cycle already compares against the new duty.
        if (wrap_c) begin
          active_nxt = pending_duty;
          eff_duty_c = pending_duty;
          state_nxt  = S_EMPTY;
        end
      end
      default: begin
        state_nxt = S_EMPTY;
      end
    endcase
  end

  // Duty registers. duty_ready is registered from the next pending state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_duty <= '0;
      active_duty  <= RST_DUTY;
      duty_ready   <= 1'b1;
    end else begin
      pending_duty <= pending_nxt;
      active_duty  <= active_nxt;
      duty_ready   <= (state_nxt == S_EMPTY);
    end
  end

  // Registered PWM, wrap pulse, wrap tally and sticky sequence error.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out    <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= '0;
      seq_err    <= 1'b0;
    end else begin
      pwm_out    <= en && ({1'b0, count_in} < eff_duty_c);
      wrap_pulse <= wrap_c;
      wrap_cnt   <= wrap_cnt + CW'(wrap_c);
      seq_err    <= seq_err | err_c;
    end
  end

endmodule

// File: tb/tb_count_pwm_gen.sv
// Testbench for count_pwm_gen. A cycle reference model pushes the expected
// outputs to a scoreboard. A duty table checks the number of high cycles
// per period. Hand sequences cover the multi-cycle corner cases.
module tb_count_pwm_gen;

  logic       clk;
  logic       rst;
  logic [5:0] count_in;
  logic       en;
  logic [6:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic       pwm_out;
  logic       wrap_pulse;
  logic [7:0] wrap_cnt;
  logic       seq_err;

  count_pwm_gen #(.WIDTH(6), .DEFAULT_DUTY(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .count_in   (count_in),
    .en         (en),
    .duty_in    (duty_in),
    .duty_valid (duty_valid),
    .duty_ready (duty_ready),
    .pwm_out    (pwm_out),
    .wrap_pulse (wrap_pulse),
    .wrap_cnt   (wrap_cnt),
    .seq_err    (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit pwm;
    bit wp;
    bit ready;
    int wc;
    bit err;
  } exp_t;

  typedef struct {
    int duty;
    bit en;
    int exp_high;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state.
  int m_prev, m_active, m_pend, m_wc;
  bit m_pv, m_pend_full, m_ready, m_err;

  int cnt;
  bit en_r;
  bit last_pwm;

  function automatic void chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endfunction

  // Drive one cycle, predict the outputs, then compare after the edge.
  task automatic step(input bit r, input int c, input bit e, input bit dv, input int d);
    exp_t x;
    bit   wrap, stp, err;
    int   eff;
    @(negedge clk);
    rst = r; count_in = 6'(c); en = e; duty_valid = dv; duty_in = 7'(d);
    if (r) begin
      m_pv = 0; m_active = 0; m_pend_full = 0; m_ready = 1; m_wc = 0; m_err = 0;
      x = '{pwm: 0, wp: 0, ready: 1, wc: 0, err: 0};
    end else begin
      wrap = m_pv && m_prev == 63 && c == 0;
      stp  = m_pv && !wrap && (c == m_prev + 1 || c == m_prev);
      err  = m_pv && !wrap && !stp && c != 0;
      eff  = m_active;
      if (wrap && m_pend_full) begin
        m_active = m_pend; m_pend_full = 0; eff = m_active;
      end
      if (dv && m_ready) begin
        m_pend = (d > 64) ? 64 : d; m_pend_full = 1;
      end
      m_ready = !m_pend_full;
      m_wc    = (m_wc + (wrap ? 1 : 0)) % 256;
      m_err   = m_err | err;
      x = '{pwm: e && (c < eff), wp: wrap, ready: m_ready, wc: m_wc, err: m_err};
    end
    m_prev = c; m_pv = !r;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: got empty queue want 1 entry");
    end else begin
      x = sb.pop_front();
      chk("sb_pwm_out", int'(pwm_out), int'(x.pwm));
      chk("sb_wrap_pulse", int'(wrap_pulse), int'(x.wp));
      chk("sb_duty_ready", int'(duty_ready), int'(x.ready));
      chk("sb_wrap_cnt", int'(wrap_cnt), x.wc);
      chk("sb_seq_err", int'(seq_err), int'(x.err));
    end
    last_pwm = pwm_out;
  endtask

  task automatic tick(input bit dv, input int d);
    step(0, cnt, en_r, dv, d);
    cnt = (cnt + 1) % 64;
  endtask

  task automatic run_to_wrap();
    while (cnt != 0) tick(0, 0);
    tick(0, 0);
  endtask

  // High cycles in the period that starts with the wrap tick just done.
  task automatic finish_period(output int highs);
    highs = int'(last_pwm);
    repeat (63) begin
      tick(0, 0);
      highs += int'(last_pwm);
    end
  endtask

  initial begin
    vec_t tab[9];
    int   highs, wc0;

    tab[0] = '{duty: 16,  en: 1, exp_high: 16};
    tab[1] = '{duty: 40,  en: 1, exp_high: 40};
    tab[2] = '{duty: 0,   en: 1, exp_high: 0};
    tab[3] = '{duty: 64,  en: 1, exp_high: 64};
    tab[4] = '{duty: 100, en: 1, exp_high: 64};
    tab[5] = '{duty: 127, en: 1, exp_high: 64};
    tab[6] = '{duty: 1,   en: 1, exp_high: 1};
    tab[7] = '{duty: 63,  en: 1, exp_high: 63};
    tab[8] = '{duty: 32,  en: 0, exp_high: 0};

    rst = 1; count_in = 0; en = 0; duty_in = 0; duty_valid = 0;
    cnt = 0; en_r = 1; last_pwm = 0;
    m_prev = 0; m_active = 0; m_pend = 0; m_wc = 0;
    m_pv = 0; m_pend_full = 0; m_ready = 1; m_err = 0;

    // Reset for two cycles.
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    chk("rst_duty_ready", int'(duty_ready), 1);
    chk("rst_pwm_out", int'(pwm_out), 0);
    chk("rst_wrap_cnt", int'(wrap_cnt), 0);

    // Duty table: write at count 20, measure the full period after the wrap.
    foreach (tab[i]) begin
      en_r = tab[i].en;
      while (cnt != 20) tick(0, 0);
      tick(1, tab[i].duty);
      chk("tab_ready_drop", int'(duty_ready), 0);
      run_to_wrap();
      chk("tab_ready_back", int'(duty_ready), 1);
      finish_period(highs);
      chk($sformatf("tab_period_high[%0d]", i), highs, tab[i].exp_high);
    end
    en_r = 1;

    // Duty 16 active. Writing 40 mid-period leaves that period at 16.
    while (cnt != 5) tick(0, 0);
    tick(1, 16);
    run_to_wrap();
    finish_period(highs);
    chk("t3_first_period", highs, 16);
    while (cnt != 20) tick(0, 0);
    tick(1, 40);
    chk("t3_ready_low", int'(duty_ready), 0);
    highs = 0;
    while (cnt != 0) begin
      tick(0, 0);
      highs += int'(last_pwm);
    end
    chk("t3_tail_old_duty", highs, 0);
    chk("t3_ready_low_at_end", int'(duty_ready), 0);
    wc0 = int'(wrap_cnt);
    tick(0, 0);
    chk("t3_wrap_pulse", int'(wrap_pulse), 1);
    chk("t3_wrap_cnt_inc", int'(wrap_cnt), (wc0 + 1) % 256);
    chk("t3_new_duty_at_wrap", int'(last_pwm), 1);
    finish_period(highs);
    chk("t3_new_period", highs, 40);

    // Accept on a wrap cycle with pending empty. It applies one wrap later.
    tick(1, 8);
    chk("t6_accept_on_wrap_ready", int'(duty_ready), 0);
    finish_period(highs);
    chk("t6_period_keeps_40", highs, 40);
    tick(0, 0);
    finish_period(highs);
    chk("t6_period_now_8", highs, 8);
    tick(0, 0); tick(0, 0); tick(0, 0);
    en_r = 0;
    tick(0, 0);
    chk("t6_en_low_forces_pwm", int'(pwm_out), 0);
    en_r = 1;
    tick(0, 0);
    chk("t6_en_back_pwm", int'(pwm_out), 1);

    // Illegal jump sets seq_err. A later jump to 0 resyncs without a wrap.
    while (cnt != 10) tick(0, 0);
    tick(0, 0);
    step(0, 13, en_r, 0, 0);
    chk("t5_seq_err_set", int'(seq_err), 1);
    cnt = 14;
    while (cnt != 31) tick(0, 0);
    wc0 = int'(wrap_cnt);
    step(0, 0, en_r, 0, 0);
    cnt = 1;
    chk("t5_resync_no_pulse", int'(wrap_pulse), 0);
    chk("t5_resync_wrap_cnt", int'(wrap_cnt), wc0);
    chk("t5_err_sticky", int'(seq_err), 1);
    repeat (5) tick(0, 0);
    chk("t5_err_still_sticky", int'(seq_err), 1);

    // Reset mid-period with a pending duty discards that duty.
    while (cnt != 40) tick(0, 0);
    tick(1, 50);
    step(1, cnt, en_r, 0, 0); cnt = (cnt + 1) % 64;
    step(1, cnt, en_r, 0, 0); cnt = (cnt + 1) % 64;
    chk("rst2_seq_err_clear", int'(seq_err), 0);
    chk("rst2_ready", int'(duty_ready), 1);
    chk("rst2_wrap_cnt", int'(wrap_cnt), 0);
    run_to_wrap();
    finish_period(highs);
    chk("rst2_pending_discarded", highs, 0);

    // wrap_cnt is now 1. After 254 more wraps it reads 255, then it rolls to 0.
    repeat (254) repeat (64) tick(0, 0);
    chk("wrap_cnt_255", int'(wrap_cnt), 255);
    repeat (64) tick(0, 0);
    chk("wrap_cnt_rollover", int'(wrap_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
